// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID pipeline record for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned  DEF_A_LENGTH  = 12;
  localparam logic [31:0]  DEF_RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0]  DEF_IMEM_BASE = 32'hBFC0_0000;
  localparam logic [31:0]  DEF_NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // A bubble carries the NOP encoding but zeroed PCs and no valid bit.
  function automatic if_id_t make_bubble(input logic [31:0] nop_instr);
    if_id_t b;
    b.instr    = nop_instr;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, and a refused load becomes a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q,
  output logic   loaded
);

  // Reports the edges where a real instruction is captured, so the
  // instruction counter shares exactly this priority decision.
  always_comb begin
    loaded = 1'b0;
    if (!flush && !stall && load)
      loaded = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= make_bubble(NOP_INSTR);
    end else if (flush) begin
      q <= make_bubble(NOP_INSTR);
    end else if (stall) begin
      q <= q;
    end else if (!load) begin
      q <= make_bubble(NOP_INSTR);
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the ROM address and feeds the IF/ID register.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned A_LENGTH  = DEF_A_LENGTH,
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [31:0] IMEM_BASE = DEF_IMEM_BASE,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_f,
  input  logic                stall_d,
  input  logic                flush_d,
  input  logic                pc_src_e,
  input  logic [31:0]         pc_target_e,
  output logic [A_LENGTH-1:0] imem_addr,
  input  logic [31:0]         imem_rd,
  output logic [31:0]         pc_f,
  output logic [31:0]         instr_d,
  output logic [31:0]         pc_d,
  output logic [31:0]         pc_plus4_d,
  output logic                valid_d,
  output logic                fetch_fault,
  output logic [31:0]         fetch_count
);

  // Address of the last whole word inside the fetch window.
  localparam logic [31:0] WIN_LAST = IMEM_BASE + 32'((33'd1 << A_LENGTH) - 33'd4);

  logic        bad;
  logic [31:0] pc_plus4_f;
  logic        if_id_load;
  logic        if_id_loaded;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  assign imem_addr  = pc_f[A_LENGTH-1:0];
  assign pc_plus4_f = pc_f + 32'd4;

  always_comb begin
    bad = 1'b0;
    if ((pc_f < IMEM_BASE) || (pc_f > WIN_LAST) || (pc_f[1:0] != 2'b00))
      bad = 1'b1;
  end

  // A redirect is honoured even while stalled; the fault is only raised when
  // the bad PC would otherwise advance, so a redirect can still escape it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f        <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (fetch_fault) begin
      pc_f        <= pc_f;
    end else if (pc_src_e) begin
      pc_f        <= pc_target_e;
    end else if (stall_f) begin
      pc_f        <= pc_f;
    end else if (bad) begin
      fetch_fault <= 1'b1;
    end else begin
      pc_f        <= pc_plus4_f;
    end
  end

  always_comb begin
    if_id_d          = make_bubble(NOP_INSTR);
    if_id_d.instr    = imem_rd;
    if_id_d.pc       = pc_f;
    if_id_d.pc_plus4 = pc_plus4_f;
    if_id_d.valid    = 1'b1;
    if_id_load       = !bad && !fetch_fault;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall_d),
    .flush  (flush_d),
    .load   (if_id_load),
    .d      (if_id_d),
    .q      (if_id_q),
    .loaded (if_id_loaded)
  );

  assign instr_d    = if_id_q.instr;
  assign pc_d       = if_id_q.pc;
  assign pc_plus4_d = if_id_q.pc_plus4;
  assign valid_d    = if_id_q.valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fetch_count <= '0;
    else if (if_id_loaded)
      fetch_count <= fetch_count + 32'd1;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the 4 KiB byte-addressed instruction ROM, which spans 0xBFC00000–0xBFC00FFF, has a 12-bit address and returns 32-bit big-endian words combinationally.
- Owns the PC and the next-PC selection (sequential or branch/jump redirect).
- Drives the ROM address, captures the returned word into the IF/ID pipeline register, and presents it to decode.
- Handles stall, flush, out-of-window/misaligned fetch faults, and a fetched-instruction counter.

Parameters:
- A_LENGTH, 12, instruction ROM address width in bits.
- RESET_PC, 32'hBFC00000, PC value after reset.
- IMEM_BASE, 32'hBFC00000, base of the legal fetch window; the window size is 2**A_LENGTH bytes.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- stall_f  in  1  hold the PC.
- stall_d  in  1  hold the IF/ID register.
- flush_d  in  1  replace the IF/ID contents with a bubble.
- pc_src_e  in  1  redirect request from execute.
- pc_target_e  in  32  redirect target address.
- imem_addr  out  A_LENGTH  ROM byte address; equals pc_f[A_LENGTH-1:0].
- imem_rd  in  32  ROM read data, combinational from imem_addr.
- pc_f  out  32  current fetch PC.
- instr_d  out  32  instruction in decode.
- pc_d  out  32  PC of instr_d.
- pc_plus4_d  out  32  pc_d + 4.
- valid_d  out  1  instr_d is a real instruction (not a bubble).
- fetch_fault  out  1  sticky fault flag.
- fetch_count  out  32  number of valid instructions that have entered decode.

Behaviour:
- Reset, asynchronous and immediate, including mid-operation:
  - pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fetch_fault=0, fetch_count=0.
  - The first posedge after rst deasserts latches the word at ROM address 0.
- imem_addr is purely combinational from pc_f. There is zero cycle latency from PC to ROM data, so an instruction reaches instr_d one cycle after its PC appears on pc_f.
- Fault condition (combinational, "bad"): pc_f outside [IMEM_BASE, IMEM_BASE+2**A_LENGTH-4] or pc_f[1:0]!=0.
- PC update per posedge, in priority order:
  1. fetch_fault=1: hold.
  2. pc_src_e=1: load pc_target_e unmodified, even when stall_f=1 (redirect beats stall).
  3. stall_f=1: hold.
  4. bad=1: hold, and set fetch_fault at the same edge.
  5. Otherwise: pc_f+4 using a full 32-bit add. Wrap past the window end is not masked; it makes pc_f bad on the next cycle.
- IF/ID update per posedge, in priority order:
  1. flush_d=1: instr_d=NOP_INSTR, valid_d=0, pc_d and pc_plus4_d=0. Flush beats stall_d.
  2. stall_d=1: hold all fields.
  3. bad=1 or fetch_fault=1: bubble, same values as a flush.
  4. Otherwise: instr_d=imem_rd, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1.
- fetch_count increments by 1 at each edge where case 4 of the IF/ID update loads. It wraps modulo 2^32.
- fetch_fault is sticky until rst. Once set, pc_f, the IF/ID register and fetch_count freeze; the only exception is flush_d, which still bubbles IF/ID.
- Simultaneous pc_src_e and flush_d is the normal taken-branch case: the PC gets the target and IF/ID gets a bubble in the same edge.
- A redirect to a misaligned or out-of-window target is loaded. The fault is raised on the following edge, and no instruction from that PC enters decode.

Decomposition:
- Shared package fetch_pkg: IMEM_BASE, RESET_PC, NOP_INSTR, A_LENGTH default, and a packed struct if_id_t {instr, pc, pc_plus4, valid}.
- One natural sub-module, if_id_reg: the pipeline register with async reset, stall and flush.
- PC logic, fault detection and the counter stay in fetch_stage.

Test Plan:
- Reset sequence: assert rst, release, run 3 clocks with a ROM model → pc_f goes 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; instr_d equals the words at 0, 4, 8; valid_d=1 from cycle 1; fetch_count=3.
- Stall: stall_f=stall_d=1 for 2 cycles at pc_f=0xBFC00010 → pc_f and instr_d are held and fetch_count is unchanged. On release, fetching resumes at 0xBFC00014.
- Redirect with flush: pc_src_e=1, pc_target_e=0xBFC00100, flush_d=1, stall_f=1 → next edge pc_f=0xBFC00100, instr_d=0x00000013, valid_d=0; the edge after that, instr_d holds the word at 0x100.
- Window end: run with pc_f=0xBFC00FFC → the last word enters decode; pc_f becomes 0xBFC01000; fetch_fault=1 one edge later; pc_f freezes at 0xBFC01000; valid_d=0.
- Misaligned target: pc_target_e=0xBFC00102 → fetch_fault sets on the next edge and fetch_count is unchanged.
- Reset mid-fault: assert rst asynchronously between clock edges → fetch_fault=0, pc_f=0xBFC00000 and valid_d=0 immediately, without waiting for a clock edge.
